// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default widths for the PWM ramp controller.
`timescale 1ns/1ps
package pwm_ctrl_pkg;

  localparam int unsigned PWM_N_DEF     = 8;
  localparam int unsigned PWM_DIV_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_HOLD = 2'd3
  } pwm_state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_strobe_div.sv
// strobe_div: counts 0..cmp_i and wraps; pulse_o is high in the cycle the count equals cmp_i.
`timescale 1ns/1ps
module strobe_div #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] cmp_i,
  output logic         pulse_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // >= rather than == so a live shrink of cmp_i below the count still wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || clr_i) begin
      cnt_d = '0;
    end else if (cnt_q >= cmp_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by reset so the strobe is low during reset even when cmp_i is 0.
  assign pulse_o = rst_n & en_i & ~clr_i & (cnt_q == cmp_i);

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a PWM duty value toward a target one LSB per rate interval.
// Optional macro PWM_RAMP_BREATHE_EN makes the ramp bounce between the target and 0.
`timescale 1ns/1ps
module pwm_ramp_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int N     = PWM_N_DEF,
  parameter int DIV_W = PWM_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [N-1:0]     target,
  input  logic [DIV_W-1:0] rate,
  input  logic [DIV_W-1:0] step_div,
  output logic [N-1:0]     duty,
  output logic             step,
  output logic             pwm_ena,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state_o
);

  // start is a one-cycle request with no ready: it is taken whenever ena is high.
  pwm_state_e       state_q, state_d;
  logic [N-1:0]     duty_q, duty_d;
  logic [N-1:0]     goal_q, goal_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic             done_q, done_d;
  logic             start_acc;
  logic             ramping;
  logic             rate_tick;
`ifdef PWM_RAMP_BREATHE_EN
  logic [N-1:0]     tgt_q, tgt_d;
`endif

  assign start_acc = ena & start;
  assign ramping   = (state_q == ST_UP) || (state_q == ST_DOWN);

  strobe_div #(.W(DIV_W)) u_step_div (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (ena),
    .clr_i   (1'b0),
    .cmp_i   (step_div),
    .pulse_o (step)
  );

  strobe_div #(.W(DIV_W)) u_rate_div (
    .clk     (clk),
    .rst_n   (rst),
    .en_i    (ena & ramping),
    .clr_i   (start_acc),
    .cmp_i   (rate_q),
    .pulse_o (rate_tick)
  );

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    goal_d  = goal_q;
    rate_d  = rate_q;
    done_d  = 1'b0;
`ifdef PWM_RAMP_BREATHE_EN
    tgt_d   = tgt_q;
`endif
    if (!ena) begin
      state_d = ST_IDLE;
    end else if (start) begin
      goal_d = target;
      rate_d = rate;
`ifdef PWM_RAMP_BREATHE_EN
      tgt_d  = target;
`endif
      if (target > duty_q)      state_d = ST_UP;
      else if (target < duty_q) state_d = ST_DOWN;
      else                      state_d = ST_HOLD;
    end else if (ramping && rate_tick) begin
      if (state_q == ST_UP) begin
        if (duty_q != '1) duty_d = duty_q + 1'b1;
      end else begin
        if (duty_q != '0) duty_d = duty_q - 1'b1;
      end
      if (duty_d == goal_q) begin
`ifdef PWM_RAMP_BREATHE_EN
        // Arrival at the target turns toward 0; arrival at 0 turns back up.
        if (goal_q == tgt_q) done_d = 1'b1;
        if (tgt_q == '0) begin
          state_d = ST_HOLD;
        end else if (goal_q == tgt_q) begin
          goal_d  = '0;
          state_d = ST_DOWN;
        end else begin
          goal_d  = tgt_q;
          state_d = ST_UP;
        end
`else
        state_d = ST_HOLD;
        done_d  = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      goal_q  <= '0;
      rate_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      goal_q  <= goal_d;
      rate_q  <= rate_d;
      done_q  <= done_d;
    end
  end

`ifdef PWM_RAMP_BREATHE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tgt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
    end
  end
`endif

  assign duty        = duty_q;
  assign busy        = ramping;
  assign pwm_ena     = ena & (state_q != ST_IDLE);
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
